// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the double-buffered register bank and its burst sequencer.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } seq_state_t;

  localparam int GAP_CNT_W = 8;

  // True when every one of the low `nibbles` nibbles of value is a decimal digit.
  function automatic logic is_bcd(input logic [31:0] value, input int nibbles);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if ((i < nibbles) && (value[i*4 +: 4] > 4'd9)) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/reg_burst_seq.sv
// Burst sequencer: IDLE -> SEND (one beat per handshake, indices 0..N_REGS-1) -> GAP hold -> IDLE.
module reg_burst_seq
  import reg_bank_pkg::*;
#(
  parameter int N_REGS  = 11,
  parameter int IDX_W   = 4,
  parameter int GAP_CYC = 22
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] idx,
  output logic             busy
);

  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_REGS - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

  seq_state_t           state;
  seq_state_t           next_state;
  logic [IDX_W-1:0]     next_idx;
  logic [GAP_CNT_W-1:0] gap_cnt;
  logic [GAP_CNT_W-1:0] next_gap;

  // State, beat index and gap counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= next_state;
      idx     <= next_idx;
      gap_cnt <= next_gap;
    end
  end

  // Next-state logic; the index returns to 0 as the last beat is accepted.
  always_comb begin
    next_state = state;
    next_idx   = idx;
    next_gap   = gap_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = SEND;
          next_idx   = '0;
        end else begin
          next_state = IDLE;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (idx == LAST_IDX) begin
            next_idx   = '0;
            next_gap   = '0;
            next_state = (GAP_CYC == 0) ? IDLE : GAP;
          end else begin
            next_idx = idx + {{(IDX_W-1){1'b0}}, 1'b1};
          end
        end else begin
          next_state = SEND;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          next_state = IDLE;
        end else begin
          next_gap = gap_cnt + {{(GAP_CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        next_state = IDLE;
        next_idx   = '0;
        next_gap   = '0;
      end
    endcase
  end

  assign out_valid = (state == SEND);
  assign busy      = (state != IDLE);

endmodule

// File: rtl/reg_bank_burst.sv
// Double-buffered register bank with indexed capture, atomic commit and a valid/ready output burst.
// Optional macro REG_BANK_BCD_CHECK_EN rejects writes containing any non-decimal nibble.
module reg_bank_burst
  import reg_bank_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int N_REGS  = 11,
  parameter int IDX_W   = 4,
  parameter int GAP_CYC = 22
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              commit,
  input  logic              start,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_first,
  output logic              out_last,
  output logic              busy,
  output logic              frame_full,
  output logic              committed,
  output logic              wr_err
);

  localparam logic [IDX_W:0]   NUM_REGS = (IDX_W+1)'(N_REGS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REGS - 1);

  logic [DATA_W-1:0] cap  [N_REGS];
  logic [DATA_W-1:0] disp [N_REGS];
  logic [N_REGS-1:0] mask;
  logic              pending;
  logic              idx_ok;
  logic              val_ok;
  logic              wr_ok;
  logic              apply;
  logic              start_go;
  logic              seq_valid;
  logic [IDX_W-1:0]  seq_idx;

  assign idx_ok = ({1'b0, wr_idx} < NUM_REGS);
`ifdef REG_BANK_BCD_CHECK_EN
  assign val_ok = is_bcd(32'(wr_data), DATA_W / 4);
`else
  assign val_ok = 1'b1;
`endif
  assign wr_ok = wr_en && idx_ok && val_ok;

  // A commit only lands while idle, so the display bank is frozen for the whole burst.
  assign apply    = !busy && (commit || pending);
  assign start_go = start && !pending;

  // Banks, capture mask, commit bookkeeping and the sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_REGS; i++) begin
        cap[i]  <= '0;
        disp[i] <= '0;
      end
      mask      <= '0;
      pending   <= 1'b0;
      committed <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      if (apply) begin
        disp <= cap;
        mask <= '0;
      end
      // Placed after the clear so a same-cycle write keeps its mask bit.
      if (wr_ok) begin
        cap[wr_idx]  <= wr_data;
        mask[wr_idx] <= 1'b1;
      end
      if (apply) begin
        pending <= 1'b0;
      end else if (commit && busy) begin
        pending <= 1'b1;
      end
      committed <= apply;
      wr_err    <= wr_err | (wr_en && !wr_ok);
    end
  end

  reg_burst_seq #(
    .N_REGS  (N_REGS),
    .IDX_W   (IDX_W),
    .GAP_CYC (GAP_CYC)
  ) u_seq (
    .clk       (clk),
    .reset     (reset),
    .start     (start_go),
    .out_ready (out_ready),
    .out_valid (seq_valid),
    .idx       (seq_idx),
    .busy      (busy)
  );

  assign out_valid  = seq_valid;
  assign out_idx    = seq_idx;
  assign out_data   = seq_valid ? disp[seq_idx] : '0;
  assign out_first  = seq_valid && (seq_idx == '0);
  assign out_last   = seq_valid && (seq_idx == LAST_IDX);
  assign frame_full = &mask;

endmodule
